// File: rtl/test_frontend.sv
`default_nettype none
// ============================================================================
// Module : test_frontend
// Brief  : Clock dividers, ADC capture and framed PC command parser.
// Rev    : 1.0
// ============================================================================
module test_frontend #(
    parameter int         OUT_HALF  = 1,
    parameter int         DUT_HALF  = 2,
    parameter int         ADC_HALF  = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_cmd_valid,
    input  logic [7:0]  pc_cmd_data,
    output logic        pc_ack,
    output logic        cfg_err,
    output logic        config_en,
    output logic [31:0] config_data,
    input  logic [15:0] adc_in,
    output logic [15:0] adc_data,
    output logic        adc_ready,
    output logic        clk_out,
    output logic        dut_clk,
    output logic        adc_clk,
    output logic [31:0] dut_clk_counter,
    output logic [31:0] adc_clk_counter
);

    localparam int          NDIV    = 3;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    logic [NDIV-1:0] div_out;
    logic [NDIV-1:0] at_last;
    logic            dut_rise;
    logic            adc_rise;

    // Index 0: clk_out, 1: dut_clk, 2: adc_clk
    generate
        for (genvar g = 0; g < NDIV; g++) begin : g_div
            localparam int          HALF = (g == 0) ? OUT_HALF : (g == 1) ? DUT_HALF : ADC_HALF;
            localparam logic [31:0] LAST = 32'(HALF - 1);
            logic [31:0] cnt;
            logic        q;

            assign at_last[g] = (cnt == LAST);
            assign div_out[g] = q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt <= '0;
                    q   <= 1'b0;
                end else if (at_last[g]) begin
                    cnt <= '0;
                    q   <= ~q;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    endgenerate

    assign clk_out  = div_out[0];
    assign dut_clk  = div_out[1];
    assign adc_clk  = div_out[2];
    assign dut_rise = at_last[1] & ~div_out[1];
    assign adc_rise = at_last[2] & ~div_out[2];

    logic [15:0] adc_s1;
    logic [15:0] adc_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adc_s1          <= '0;
            adc_s2          <= '0;
            adc_data        <= '0;
            adc_ready       <= 1'b0;
            dut_clk_counter <= '0;
            adc_clk_counter <= '0;
        end else begin
            adc_s1    <= adc_in;
            adc_s2    <= adc_s1;
            adc_ready <= adc_rise;
            if (adc_rise) begin
                adc_data        <= adc_s2;
                adc_clk_counter <= adc_clk_counter + 32'd1;
            end
            if (dut_rise) begin
                dut_clk_counter <= dut_clk_counter + 32'd1;
            end
        end
    end

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  xor_acc;
    logic [31:0] shadow;
    logic [31:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            xor_acc     <= '0;
            shadow      <= '0;
            idle_cnt    <= '0;
            config_data <= '0;
            config_en   <= 1'b0;
            pc_ack      <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            config_en <= 1'b0;
            pc_ack    <= 1'b0;
            cfg_err   <= 1'b0;
            if (state != IDLE && !pc_cmd_valid) begin
                // Silence inside a frame aborts it once the budget runs out
                if (idle_cnt == TO_LAST) begin
                    cfg_err  <= 1'b1;
                    idle_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end else if (pc_cmd_valid) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (pc_cmd_data == SYNC_BYTE) begin
                            byte_cnt <= '0;
                            xor_acc  <= '0;
                            state    <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        shadow   <= {shadow[23:0], pc_cmd_data};
                        xor_acc  <= xor_acc ^ pc_cmd_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (pc_cmd_data == xor_acc) begin
                            config_data <= shadow;
                            config_en   <= 1'b1;
                            pc_ack      <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_test_frontend
// Brief  : Directed self-checking bench for test_frontend.
// Rev    : 1.0
// ============================================================================
module tb_test_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_cmd_valid;
    logic [7:0]  pc_cmd_data;
    logic        pc_ack;
    logic        cfg_err;
    logic        config_en;
    logic [31:0] config_data;
    logic [15:0] adc_in;
    logic [15:0] adc_data;
    logic        adc_ready;
    logic        clk_out;
    logic        dut_clk;
    logic        adc_clk;
    logic [31:0] dut_clk_counter;
    logic [31:0] adc_clk_counter;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_frontend dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_cmd_valid    (pc_cmd_valid),
        .pc_cmd_data     (pc_cmd_data),
        .pc_ack          (pc_ack),
        .cfg_err         (cfg_err),
        .config_en       (config_en),
        .config_data     (config_data),
        .adc_in          (adc_in),
        .adc_data        (adc_data),
        .adc_ready       (adc_ready),
        .clk_out         (clk_out),
        .dut_clk         (dut_clk),
        .adc_clk         (adc_clk),
        .dut_clk_counter (dut_clk_counter),
        .adc_clk_counter (adc_clk_counter)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one byte for one cycle; returns at the following negedge with valid low
    task automatic send_byte(input logic [7:0] b);
        pc_cmd_valid = 1'b1;
        pc_cmd_data  = b;
        @(negedge clk);
        pc_cmd_valid = 1'b0;
        pc_cmd_data  = 8'h00;
    endtask

    task automatic check_accept(input string tag, input logic [31:0] exp_data);
        check({tag, "_ack"},  {31'd0, pc_ack},    32'd1);
        check({tag, "_en"},   {31'd0, config_en}, 32'd1);
        check({tag, "_err"},  {31'd0, cfg_err},   32'd0);
        check({tag, "_data"}, config_data,        exp_data);
        @(negedge clk);
        check({tag, "_ack_off"}, {31'd0, pc_ack},    32'd0);
        check({tag, "_en_off"},  {31'd0, config_en}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;

        rst_n        = 1'b0;
        pc_cmd_valid = 1'b0;
        pc_cmd_data  = 8'h00;
        adc_in       = 16'hBEEF;
        repeat (3) @(negedge clk);

        check("rst_clk_out",  {31'd0, clk_out},   32'd0);
        check("rst_dut_clk",  {31'd0, dut_clk},   32'd0);
        check("rst_adc_clk",  {31'd0, adc_clk},   32'd0);
        check("rst_cfg_data", config_data,        32'd0);
        check("rst_adc_data", {16'd0, adc_data},  32'd0);
        check("rst_pulses",   {29'd0, pc_ack, cfg_err, config_en}, 32'd0);
        check("rst_dut_cnt",  dut_clk_counter,    32'd0);
        check("rst_adc_cnt",  adc_clk_counter,    32'd0);

        // Divider waveforms over the first 12 edges after release
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("clk_out_e%0d", k), {31'd0, clk_out}, 32'(k % 2));
            check($sformatf("dut_clk_e%0d", k), {31'd0, dut_clk}, 32'((k / 2) % 2));
            check($sformatf("adc_clk_e%0d", k), {31'd0, adc_clk}, 32'((k / 5) % 2));
            if (k == 4) begin
                check("adc_cnt_e4",   adc_clk_counter,     32'd0);
                check("adc_ready_e4", {31'd0, adc_ready},  32'd0);
            end
            if (k == 5) begin
                check("adc_cnt_e5",   adc_clk_counter,     32'd1);
                check("adc_ready_e5", {31'd0, adc_ready},  32'd1);
                check("adc_data_e5",  {16'd0, adc_data},   32'h0000BEEF);
            end
            if (k == 12) begin
                check("dut_cnt_e12", dut_clk_counter, 32'd3);
                check("adc_cnt_e12", adc_clk_counter, 32'd1);
            end
        end

        // Valid frame
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
        check_accept("frame1", 32'h12345678);

        // Bad checksum
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h09);
        check("badck_err",  {31'd0, cfg_err},   32'd1);
        check("badck_ack",  {31'd0, pc_ack},    32'd0);
        check("badck_en",   {31'd0, config_en}, 32'd0);
        check("badck_data", config_data,        32'h12345678);
        @(negedge clk);
        check("badck_err_off", {31'd0, cfg_err}, 32'd0);

        // Timeout after A5 12: error after exactly 256 idle cycles
        send_byte(8'hA5); send_byte(8'h12);
        n = 0;
        while (!cfg_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd256);
        check("timeout_err",    {31'd0, cfg_err},   32'd1);
        check("timeout_en",     {31'd0, config_en}, 32'd0);
        check("timeout_data",   config_data,        32'h12345678);
        @(negedge clk);

        send_byte(8'hA5); send_byte(8'hDE); send_byte(8'hAD);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h22);
        check_accept("frame2", 32'hDEADBEEF);

        // Sync byte inside payload is plain data
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hA4);
        check_accept("frame_sync_data", 32'hA5000001);

        // ADC capture cadence and step response
        n = 0;
        while (!adc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("adc_found",    {31'd0, adc_ready}, 32'd1);
        check("adc_steady",   {16'd0, adc_data},  32'h0000BEEF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_ready && n < 20);
        check("adc_period",   32'(n),            32'd10);
        check("adc_steady2",  {16'd0, adc_data}, 32'h0000BEEF);
        adc_in = 16'h1234;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adc_ready && n < 20);
        check("adc_period2",  32'(n),            32'd10);
        check("adc_step",     {16'd0, adc_data}, 32'h00001234);
        @(negedge clk);
        check("adc_ready_off", {31'd0, adc_ready}, 32'd0);

        // Reset mid-frame discards the partial frame
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_data",    config_data,        32'd0);
        check("mid_rst_adc",     {16'd0, adc_data},  32'd0);
        check("mid_rst_clks",    {29'd0, clk_out, dut_clk, adc_clk}, 32'd0);
        check("mid_rst_cnts",    dut_clk_counter | adc_clk_counter,  32'd0);
        rst_n = 1'b1;
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (pc_ack || config_en || cfg_err) pulses++;
            @(negedge clk);
        end
        check("post_rst_no_pulse", 32'(pulses), 32'd0);
        check("post_rst_data",     config_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
